prim_count_bank: RTL and testbench

- Parametrised bank of NumChan independent hardened cross counters.
- Each channel holds a primary up-counter and a secondary down-counter. Their W-bit sum must always equal 2**Width-1.
- Adds two features per channel: selectable saturate/wrap arithmetic and a threshold-hit flag. Also provides a one-cycle overflow/underflow event pulse and a bank-wide error OR.
- Used by peripherals (UART FIFOs, timeouts, retry counters) that need several protected counters behind a single alert source.

---
 rtl/prim_count_bank.sv | 172 +++++++++++++++++
 tb/tb_prim_count_bank.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_count_bank.sv
// prim_count_bank
//
// Bank of NumChan independent hardened cross counters. Each channel keeps a
// primary up-counter and a secondary down-counter whose Width-bit sum must
// always equal all-ones. Any disagreement raises a per-channel error and a
// bank-wide error OR, so several protected counters share one alert source.
// Each channel also offers saturate or wrap arithmetic (WrapMode), a
// threshold-hit flag and a one-cycle over/underflow pulse.
//
// Optional build macro: PRIM_COUNT_BANK_STICKY_ERR_EN
//   defined   -> err_o / err_any_o latch on the first mismatch until rst_ni
//   undefined -> err_o / err_any_o follow the cross-check with 1-cycle delay
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clr_i                per-channel clear to ResetValue (highest priority)
//   set_i, set_cnt_i     per-channel load of the channel's set_cnt_i slice
//   incr_en_i, decr_en_i per-channel count direction (both = no change)
//   step_i               per-channel step size
//   commit_i             per-channel enable for registering the next state
//   thresh_i             per-channel unsigned compare value
//   cnt_o                primary counter values
//   cnt_after_commit_o   prospective primary value if the command commits
//   thr_hit_o            cnt_o slice >= thresh_i slice
//   ovf_o                pulse after a committed over/underflow
//   err_o, err_any_o     registered cross-check errors
module prim_count_bank #(
  parameter int unsigned      NumChan    = 4,
  parameter int unsigned      Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter bit               WrapMode   = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumChan-1:0]       clr_i,
  input  logic [NumChan-1:0]       set_i,
  input  logic [NumChan*Width-1:0] set_cnt_i,
  input  logic [NumChan-1:0]       incr_en_i,
  input  logic [NumChan-1:0]       decr_en_i,
  input  logic [NumChan*Width-1:0] step_i,
  input  logic [NumChan-1:0]       commit_i,
  input  logic [NumChan*Width-1:0] thresh_i,
  output logic [NumChan*Width-1:0] cnt_o,
  output logic [NumChan*Width-1:0] cnt_after_commit_o,
  output logic [NumChan-1:0]       thr_hit_o,
  output logic [NumChan-1:0]       ovf_o,
  output logic [NumChan-1:0]       err_o,
  output logic                     err_any_o
);

  localparam logic [Width-1:0] AllOnes  = {Width{1'b1}};
  localparam logic [Width-1:0] SecReset = AllOnes - ResetValue;

  logic [NumChan-1:0][Width-1:0] cnt_q, cnt_d;
  logic [NumChan-1:0][Width-1:0] sec_q, sec_d;
  logic [NumChan-1:0]            ovf_q, ovf_d;
  logic [NumChan-1:0]            err_q, err_d;
  logic                          err_any_q, err_any_d;

  logic [NumChan-1:0][Width-1:0] step;
  logic [NumChan-1:0][Width-1:0] set_val;
  logic [NumChan-1:0][Width:0]   pri_up, pri_dn, sec_up, sec_dn;
  logic [NumChan-1:0][Width-1:0] nxt_cnt, nxt_sec;
  logic [NumChan-1:0]            nxt_ovf;
  logic [NumChan-1:0]            mismatch;

  // Per-channel next-state. Arithmetic is done one bit wider than the counter
  // so the top bit is the carry (incr) or borrow (decr). The secondary moves
  // in the opposite direction by the same step, so its borrow coincides with
  // the primary's carry and vice versa; the primary's bit drives ovf.
  always_comb begin
    cnt_d              = cnt_q;
    sec_d              = sec_q;
    ovf_d              = '0;
    step               = '0;
    set_val            = '0;
    pri_up             = '0;
    pri_dn             = '0;
    sec_up             = '0;
    sec_dn             = '0;
    nxt_cnt            = cnt_q;
    nxt_sec            = sec_q;
    nxt_ovf            = '0;
    mismatch           = '0;
    cnt_o              = '0;
    cnt_after_commit_o = '0;
    thr_hit_o          = '0;
    for (int c = 0; c < NumChan; c++) begin
      step[c]    = step_i[c*Width +: Width];
      set_val[c] = set_cnt_i[c*Width +: Width];
      pri_up[c]  = {1'b0, cnt_q[c]} + {1'b0, step[c]};
      pri_dn[c]  = {1'b0, cnt_q[c]} - {1'b0, step[c]};
      sec_up[c]  = {1'b0, sec_q[c]} + {1'b0, step[c]};
      sec_dn[c]  = {1'b0, sec_q[c]} - {1'b0, step[c]};

      if (clr_i[c]) begin
        nxt_cnt[c] = ResetValue;
        nxt_sec[c] = SecReset;
      end else if (set_i[c]) begin
        nxt_cnt[c] = set_val[c];
        nxt_sec[c] = AllOnes - set_val[c];
      end else if (incr_en_i[c] && !decr_en_i[c]) begin
        // A saturating counter already at the top just holds, without a
        // fresh carry, so a held limit never re-pulses ovf.
        if (WrapMode || cnt_q[c] != AllOnes) begin
          nxt_ovf[c] = pri_up[c][Width];
          if (!WrapMode && pri_up[c][Width]) begin
            nxt_cnt[c] = AllOnes;
            nxt_sec[c] = '0;
          end else begin
            nxt_cnt[c] = pri_up[c][Width-1:0];
            nxt_sec[c] = sec_dn[c][Width-1:0];
          end
        end
      end else if (decr_en_i[c] && !incr_en_i[c]) begin
        if (WrapMode || cnt_q[c] != '0) begin
          nxt_ovf[c] = pri_dn[c][Width];
          if (!WrapMode && pri_dn[c][Width]) begin
            nxt_cnt[c] = '0;
            nxt_sec[c] = AllOnes;
          end else begin
            nxt_cnt[c] = pri_dn[c][Width-1:0];
            nxt_sec[c] = sec_up[c][Width-1:0];
          end
        end
      end

      if (commit_i[c]) begin
        cnt_d[c] = nxt_cnt[c];
        sec_d[c] = nxt_sec[c];
        ovf_d[c] = nxt_ovf[c];
      end

      // Cross-check on the stored state, extended so a wrapped sum is caught.
      mismatch[c] = ({1'b0, cnt_q[c]} + {1'b0, sec_q[c]}) != {1'b0, AllOnes};

      cnt_o[c*Width +: Width]              = cnt_q[c];
      cnt_after_commit_o[c*Width +: Width] = nxt_cnt[c];
      thr_hit_o[c] = cnt_q[c] >= thresh_i[c*Width +: Width];
    end

`ifdef PRIM_COUNT_BANK_STICKY_ERR_EN
    err_d     = err_q | mismatch;
    err_any_d = err_any_q | (|mismatch);
`else
    err_d     = mismatch;
    err_any_d = |mismatch;
`endif
  end

  // State registers; reset discards any command in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= {NumChan{ResetValue}};
      sec_q     <= {NumChan{SecReset}};
      ovf_q     <= '0;
      err_q     <= '0;
      err_any_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sec_q     <= sec_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      err_any_q <= err_any_d;
    end
  end

  assign ovf_o     = ovf_q;
  assign err_o     = err_q;
  assign err_any_o = err_any_q;

endmodule

// File: tb/tb_prim_count_bank.sv
// Testbench for prim_count_bank. Two instances share the same stimulus: one
// saturating (WrapMode=0) and one wrapping (WrapMode=1). A behavioural model
// in plain integer arithmetic predicts every output each cycle, and directed
// steps add hand-computed literal expectations.
module tb_prim_count_bank;

  localparam int NC = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_ni;
  logic [NC-1:0]   clr, set, incr, decr, commit;
  logic [NC*W-1:0] set_cnt, step, thresh;

  logic [NC*W-1:0]       cnt_out [2];
  logic [NC*W-1:0]       cac_out [2];
  logic [NC-1:0]         thr_out [2];
  logic [NC-1:0]         ovf_out [2];
  logic [NC-1:0]         err_out [2];
  logic                  err_any_out [2];
  logic [NC-1:0][W-1:0]  sec_out [2];
  logic [NC-1:0][W-1:0]  force_vec;

  int tests = 0;
  int fails = 0;
  int skip_cnt = 0;

  int m_cnt [2][NC];
  int m_sec [2][NC];
  bit m_ovf [2][NC];
  bit m_err [2][NC];
  bit m_err_any [2];
  int n_cnt [2][NC];
  int n_sec [2][NC];
  bit n_ovf [2][NC];
  bit n_err [2][NC];
  bit n_err_any [2];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  prim_count_bank #(.NumChan(NC), .Width(W), .ResetValue('0), .WrapMode(1'b0)) dut_sat (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr), .set_i(set), .set_cnt_i(set_cnt),
    .incr_en_i(incr), .decr_en_i(decr), .step_i(step), .commit_i(commit),
    .thresh_i(thresh), .cnt_o(cnt_out[0]), .cnt_after_commit_o(cac_out[0]),
    .thr_hit_o(thr_out[0]), .ovf_o(ovf_out[0]), .err_o(err_out[0]),
    .err_any_o(err_any_out[0]));

  prim_count_bank #(.NumChan(NC), .Width(W), .ResetValue('0), .WrapMode(1'b1)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr), .set_i(set), .set_cnt_i(set_cnt),
    .incr_en_i(incr), .decr_en_i(decr), .step_i(step), .commit_i(commit),
    .thresh_i(thresh), .cnt_o(cnt_out[1]), .cnt_after_commit_o(cac_out[1]),
    .thr_hit_o(thr_out[1]), .ovf_o(ovf_out[1]), .err_o(err_out[1]),
    .err_any_o(err_any_out[1]));

  assign sec_out[0] = dut_sat.sec_q;
  assign sec_out[1] = dut_wrap.sec_q;

  // Single comparison point: every check bumps the shared counters.
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        m_cnt[d][c] = 0;
        m_sec[d][c] = 255;
        m_ovf[d][c] = 1'b0;
        m_err[d][c] = 1'b0;
      end
      m_err_any[d] = 1'b0;
    end
  endtask

  // What a channel's primary becomes under the command, as plain integers.
  task automatic calc(input int wrap, input int cur, input bit cl, input bit st,
                      input bit inc, input bit dec, input int sv, input int sp,
                      output int nx, output bit ov);
    nx = cur;
    ov = 1'b0;
    if (cl) nx = 0;
    else if (st) nx = sv;
    else if (inc && !dec) begin
      nx = cur + sp;
      if (nx > 255) begin
        if (wrap != 0) begin nx = nx - 256; ov = 1'b1; end
        else begin ov = (cur != 255); nx = 255; end
      end
    end else if (dec && !inc) begin
      nx = cur - sp;
      if (nx < 0) begin
        if (wrap != 0) begin nx = nx + 256; ov = 1'b1; end
        else begin ov = (cur != 0); nx = 0; end
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        int prosp;
        bit pov;
        calc(d, m_cnt[d][c], clr[c], set[c], incr[c], decr[c],
             int'(set_cnt[c*W +: W]), int'(step[c*W +: W]), prosp, pov);
        cmp($sformatf("d%0d cnt[%0d]", d, c), cnt_out[d][c*W +: W], m_cnt[d][c]);
        cmp($sformatf("d%0d cac[%0d]", d, c), cac_out[d][c*W +: W], prosp);
        cmp($sformatf("d%0d thr[%0d]", d, c), thr_out[d][c],
            m_cnt[d][c] >= int'(thresh[c*W +: W]));
        cmp($sformatf("d%0d ovf[%0d]", d, c), ovf_out[d][c], m_ovf[d][c]);
        if (!(d == 0 && c == 0 && skip_cnt > 0)) begin
          cmp($sformatf("d%0d sec[%0d]", d, c), sec_out[d][c], m_sec[d][c]);
          cmp($sformatf("d%0d err[%0d]", d, c), err_out[d][c], m_err[d][c]);
        end
      end
      if (!(d == 0 && skip_cnt > 0))
        cmp($sformatf("d%0d err_any", d), err_any_out[d], m_err_any[d]);
    end
    if (skip_cnt > 0) skip_cnt--;
  endtask

  task automatic computeNext();
    for (int d = 0; d < 2; d++) begin
      bit any_raw;
      any_raw = 1'b0;
      for (int c = 0; c < NC; c++) begin
        int nx;
        bit ov, raw;
        raw = (m_cnt[d][c] + m_sec[d][c]) != 255;
        any_raw |= raw;
        calc(d, m_cnt[d][c], clr[c], set[c], incr[c], decr[c],
             int'(set_cnt[c*W +: W]), int'(step[c*W +: W]), nx, ov);
        if (commit[c]) begin
          n_cnt[d][c] = nx;
          n_sec[d][c] = 255 - nx;
          n_ovf[d][c] = ov;
        end else begin
          n_cnt[d][c] = m_cnt[d][c];
          n_sec[d][c] = m_sec[d][c];
          n_ovf[d][c] = 1'b0;
        end
`ifdef PRIM_COUNT_BANK_STICKY_ERR_EN
        n_err[d][c] = m_err[d][c] | raw;
`else
        n_err[d][c] = raw;
`endif
      end
`ifdef PRIM_COUNT_BANK_STICKY_ERR_EN
      n_err_any[d] = m_err_any[d] | any_raw;
`else
      n_err_any[d] = any_raw;
`endif
    end
  endtask

  task automatic applyNext();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        m_cnt[d][c] = n_cnt[d][c];
        m_sec[d][c] = n_sec[d][c];
        m_ovf[d][c] = n_ovf[d][c];
        m_err[d][c] = n_err[d][c];
      end
      m_err_any[d] = n_err_any[d];
    end
  endtask

  // Model process: check on the falling edge, advance on the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ni) modelReset();
      checkOutput();
      computeNext();
      @(posedge clk);
      if (!rst_ni) modelReset();
      else applyNext();
    end
  end

  task automatic applyStimulus(input logic [NC-1:0] cl, input logic [NC-1:0] st,
                               input logic [NC-1:0] inc, input logic [NC-1:0] dec,
                               input logic [NC-1:0] cm, input logic [NC*W-1:0] sv,
                               input logic [NC*W-1:0] sp);
    clr = cl; set = st; incr = inc; decr = dec; commit = cm;
    set_cnt = sv; step = sp;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence with literal expectations.
  initial begin
    rst_ni = 1'b0;
    clr = '0; set = '0; incr = '0; decr = '0; commit = '0;
    set_cnt = '0; step = '0; thresh = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset cnt sat", cnt_out[0], 32'h0);
    cmp("reset thr sat", thr_out[0], 4'hF);
    cmp("reset sec sat ch0", sec_out[0][0], 8'hFF);
    cmp("reset ovf wrap", ovf_out[1], 4'h0);
    rst_ni = 1'b1;

    // Load 0xFE into ch0 and ch1, then push past the top twice.
    applyStimulus(4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 32'h0000FEFE, 32'h0);
    cmp("set ch0/1", cnt_out[0][15:0], 16'hFEFE);
    applyStimulus(4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 32'h0, 32'h00000303);
    cmp("sat incr cnt", cnt_out[0][15:0], 16'hFFFF);
    cmp("sat incr ovf", ovf_out[0], 4'b0011);
    cmp("wrap incr cnt", cnt_out[1][15:0], 16'h0101);
    cmp("wrap incr ovf", ovf_out[1], 4'b0011);
    cmp("wrap sec ch1", sec_out[1][1], 8'hFE);
    cmp("wrap err ch1", err_out[1][1], 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 32'h0, 32'h00000303);
    cmp("sat hold cnt", cnt_out[0][15:0], 16'hFFFF);
    cmp("sat hold ovf", ovf_out[0], 4'b0000);
    cmp("wrap 2nd cnt", cnt_out[1][15:0], 16'h0404);

    // Uncommitted increment only shows up on cnt_after_commit_o.
    applyStimulus(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 32'h0, 32'h00050000);
    cmp("nocommit cac ch2", cac_out[0][23:16], 8'h05);
    cmp("nocommit cnt ch2", cnt_out[0][23:16], 8'h00);
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 32'h00770000, 32'h00050000);
    cmp("clr wins ch2", cnt_out[0][23:16], 8'h00);

    // Threshold on ch3 at 0x10 while counting 8, 16, 24.
    thresh = 32'h10000000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 32'h0, 32'h08000000);
      cmp($sformatf("thr ch3 step%0d", i), thr_out[0][3], i > 0);
      cmp($sformatf("cnt ch3 step%0d", i), cnt_out[0][31:24], 8 * (i + 1));
    end
    applyStimulus(4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 32'h0, 32'h08000000);
    cmp("incr+decr ch3", cnt_out[1][31:24], 8'd24);

    // Underflow on ch2 from 2, then a second decrement and a zero step.
    applyStimulus(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 32'h00020000, 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 32'h0, 32'h00050000);
    cmp("sat decr cnt", cnt_out[0][23:16], 8'h00);
    cmp("sat decr ovf", ovf_out[0][2], 1'b1);
    cmp("wrap decr cnt", cnt_out[1][23:16], 8'hFD);
    cmp("wrap decr ovf", ovf_out[1][2], 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 32'h0, 32'h00050000);
    cmp("sat floor ovf", ovf_out[0][2], 1'b0);
    cmp("wrap 2nd decr", cnt_out[1][23:16], 8'hF8);
    applyStimulus(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 32'h0, 32'h0);
    cmp("step0 cnt", cnt_out[1][23:16], 8'hF8);
    cmp("step0 ovf", ovf_out[1][2], 1'b0);

    // Mixed independent traffic on all channels.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom & $urandom & $urandom), 4'($urandom & $urandom & $urandom),
                    4'($urandom), 4'($urandom), 4'($urandom | $urandom), $urandom,
                    (i % 2 == 0) ? ($urandom & 32'h0F0F0F0F) : $urandom);
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

    // Corrupt ch0's secondary in the saturating instance.
    for (int c = 0; c < NC; c++) force_vec[c] = 8'(255 - m_cnt[0][c]);
    force_vec[0] = force_vec[0] ^ 8'h01;
    m_sec[0][0] = int'(force_vec[0]);
    force dut_sat.sec_q = force_vec;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    cmp("force err ch0", err_out[0][0], 1'b1);
    cmp("force err_any", err_any_out[0], 1'b1);
    cmp("force other dut", err_any_out[1], 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    cmp("force err held", err_out[0][0], 1'b1);
    release dut_sat.sec_q;
    skip_cnt = 2;
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0, 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    cmp("restored sec ch0", sec_out[0][0], 8'hFF);
`ifdef PRIM_COUNT_BANK_STICKY_ERR_EN
    cmp("sticky err ch0", err_out[0][0], 1'b1);
    cmp("sticky err_any", err_any_out[0], 1'b1);
`else
    cmp("cleared err ch0", err_out[0][0], 1'b0);
    cmp("cleared err_any", err_any_out[0], 1'b0);
`endif

    // Asynchronous reset in the middle of a committed command.
    applyStimulus(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 32'h0, 32'h01010101);
    #2 rst_ni = 1'b0;
    #1;
    cmp("async rst cnt sat", cnt_out[0], 32'h0);
    cmp("async rst cnt wrap", cnt_out[1], 32'h0);
    cmp("async rst err_any", err_any_out[0], 1'b0);
    cmp("async rst sec", sec_out[1][2], 8'hFF);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 32'h0, 32'h02020202);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
